// File: rtl/oam_dma.sv
// OAM DMA engine: copies LENGTH bytes from {src_hi, 8'h00} into OAM when FF46 is written.
// Define DMA_BUS_CONFLICT_EN to add the cpu_bus_block output.
module oam_dma #(
    parameter int LENGTH      = 160,
    parameter int START_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_we,
    input  logic [7:0]  reg_wdata,
    output logic [7:0]  reg_rdata,
    output logic        busy,
    output logic        bus_req,
    output logic [15:0] bus_addr,
    input  logic [7:0]  bus_data,
    output logic        oam_we,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata
`ifdef DMA_BUS_CONFLICT_EN
    ,
    output logic        cpu_bus_block
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DELAY = 2'd1;
    localparam logic [1:0] XFER  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    localparam logic [8:0] LEN      = 9'(LENGTH);
    localparam logic [3:0] DLY_LAST = 4'((START_DELAY == 0) ? 0 : START_DELAY - 1);

    logic [1:0] state, state_nxt;
    logic [8:0] idx, idx_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [7:0] src_hi, src_fold;
    logic       issue;
    logic [7:0] issue_src;
    logic [7:0] issue_idx;

    // Echo RAM (E000-FFFF) mirrors work RAM at C000-DFFF.
    assign src_fold  = (reg_wdata >= 8'hE0) ? (reg_wdata & 8'hDF) : reg_wdata;
    assign oam_wdata = bus_data;

    // idx is the next index to read; XFER with idx == LENGTH is the cycle
    // in which the last read is on the bus and no new read is issued.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        issue     = 1'b0;
        issue_src = src_hi;
        issue_idx = idx[7:0];
        if (reg_we) begin
            cnt_nxt = 4'd0;
            if (START_DELAY == 0) begin
                issue     = 1'b1;
                issue_src = src_fold;
                issue_idx = 8'd0;
                idx_nxt   = 9'd1;
                state_nxt = XFER;
            end else begin
                idx_nxt   = 9'd0;
                state_nxt = DELAY;
            end
        end else begin
            case (state)
                DELAY: begin
                    if (cnt == DLY_LAST) begin
                        issue     = 1'b1;
                        issue_idx = 8'd0;
                        idx_nxt   = 9'd1;
                        state_nxt = XFER;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
                XFER: begin
                    if (idx < LEN) begin
                        issue   = 1'b1;
                        idx_nxt = idx + 9'd1;
                    end else begin
                        state_nxt = DRAIN;
                    end
                end
                DRAIN:   state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 9'd0;
            cnt       <= 4'd0;
            src_hi    <= 8'h00;
            reg_rdata <= 8'h00;
            busy      <= 1'b0;
            bus_req   <= 1'b0;
            bus_addr  <= 16'h0000;
            oam_we    <= 1'b0;
            oam_addr  <= 8'h00;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
            busy  <= (state_nxt != IDLE);
            if (reg_we) begin
                reg_rdata <= reg_wdata;
                src_hi    <= src_fold;
            end
            bus_req <= issue;
            if (issue)
                bus_addr <= {issue_src, issue_idx};
            // Write lags the read by one cycle; a read in flight at restart still lands.
            oam_we <= bus_req;
            if (bus_req)
                oam_addr <= bus_addr[7:0];
        end
    end

`ifdef DMA_BUS_CONFLICT_EN
    always_ff @(posedge clk) begin
        if (rst)
            cpu_bus_block <= 1'b0;
        else
            cpu_bus_block <= (state_nxt != IDLE);
    end
`endif

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: random sources checked against a transfer-level model of reads,
// OAM writes and busy duration, plus restart, mid-transfer reset and LENGTH=256 cases.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [7:0]  wdata;
    logic        sel;

    logic        reg_we1, reg_we2;
    logic [7:0]  rdata1, rdata2;
    logic        busy1, busy2, req1, req2, owe1, owe2;
    logic [15:0] addr1, addr2;
    logic [7:0]  bdata1, bdata2, oaddr1, oaddr2, odata1, odata2;
`ifdef DMA_BUS_CONFLICT_EN
    logic        blk1, blk2;
`endif

    always #5 clk = ~clk;

    assign reg_we1 = we && !sel;
    assign reg_we2 = we && sel;

    oam_dma #(.LENGTH(160), .START_DELAY(1)) dut (
        .clk(clk), .rst(rst), .reg_we(reg_we1), .reg_wdata(wdata), .reg_rdata(rdata1),
        .busy(busy1), .bus_req(req1), .bus_addr(addr1), .bus_data(bdata1),
        .oam_we(owe1), .oam_addr(oaddr1), .oam_wdata(odata1)
`ifdef DMA_BUS_CONFLICT_EN
        , .cpu_bus_block(blk1)
`endif
    );

    oam_dma #(.LENGTH(256), .START_DELAY(0)) dut2 (
        .clk(clk), .rst(rst), .reg_we(reg_we2), .reg_wdata(wdata), .reg_rdata(rdata2),
        .busy(busy2), .bus_req(req2), .bus_addr(addr2), .bus_data(bdata2),
        .oam_we(owe2), .oam_addr(oaddr2), .oam_wdata(odata2)
`ifdef DMA_BUS_CONFLICT_EN
        , .cpu_bus_block(blk2)
`endif
    );

    // Memory responders: data appears on the edge after the address is sampled.
    logic [7:0] mem [65536];
    always @(posedge clk) begin
        if (rst) begin
            bdata1 <= 8'h00;
            bdata2 <= 8'h00;
        end else begin
            if (req1) bdata1 <= mem[addr1];
            if (req2) bdata2 <= mem[addr2];
        end
    end

    logic        m_busy, m_req, m_owe;
    logic [15:0] m_addr;
    logic [7:0]  m_rdata, m_oaddr, m_odata;
    assign m_busy  = sel ? busy2  : busy1;
    assign m_req   = sel ? req2   : req1;
    assign m_owe   = sel ? owe2   : owe1;
    assign m_addr  = sel ? addr2  : addr1;
    assign m_rdata = sel ? rdata2 : rdata1;
    assign m_oaddr = sel ? oaddr2 : oaddr1;
    assign m_odata = sel ? odata2 : odata1;

    int ecount = 0;
    always @(posedge clk) ecount <= ecount + 1;

    logic [47:0] rq[$];
    logic [47:0] wq[$];
    logic [7:0]  oam [256];
    int          busy_cnt;
    int          blk_cnt;

    always @(negedge clk) begin
        if (m_req) rq.push_back({32'(ecount), m_addr});
        if (m_owe) begin
            wq.push_back({32'(ecount), m_oaddr, m_odata});
            oam[m_oaddr] = m_odata;
        end
        if (m_busy) busy_cnt++;
`ifdef DMA_BUS_CONFLICT_EN
        if (sel ? blk2 : blk1) blk_cnt++;
`endif
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] src_of(input logic [7:0] v);
        return (v >= 8'hE0) ? v - 8'h20 : v;
    endfunction

    int e0;

    task automatic kick(input logic [7:0] v);
        @(negedge clk);
        rq.delete();
        wq.delete();
        busy_cnt = 0;
        blk_cnt  = 0;
        e0 = ecount + 1;
        we = 1'b1;
        wdata = v;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] v);
        int L, D;
        logic [7:0] s;
        L = sel ? 256 : 160;
        D = sel ? 0 : 1;
        s = src_of(v);
        kick(v);
        repeat (L + D + 8) @(negedge clk);
        check("rdata", m_rdata, v);
        check("busy_len", busy_cnt, L + D + 1);
`ifdef DMA_BUS_CONFLICT_EN
        check("blk_len", blk_cnt, L + D + 1);
`endif
        check("rd_cnt", rq.size(), L);
        check("wr_cnt", wq.size(), L);
        for (int i = 0; i < L && i < rq.size(); i++)
            check("rd", rq[i], {32'(e0 + D + i), s, 8'(i)});
        for (int i = 0; i < L && i < wq.size(); i++)
            check("wr", wq[i], {32'(e0 + D + 1 + i), 8'(i), mem[{s, 8'(i)}]});
    endtask

    task automatic restart_test();
        int e1, n_old, bad;
        logic found;
        found = 1'b0;
        kick(8'hC0);
        for (int k = 0; k < 100; k++) begin
            if (m_req && m_addr == 16'hC031) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rst_found49", found, 1'b1);
        e1 = ecount + 1;
        we = 1'b1;
        wdata = 8'hC1;
        @(negedge clk);
        we = 1'b0;
        repeat (175) @(negedge clk);
        n_old = 0;
        foreach (rq[i]) if (rq[i][15:8] == 8'hC0) n_old++;
        check("re_old_reads", n_old, 50);
        check("re_rd_cnt", rq.size(), 210);
        check("re_wr_cnt", wq.size(), 210);
        if (rq.size() > 50) check("re_rd_first_new", rq[50], {32'(e1 + 1), 16'hC100});
        if (wq.size() > 49) check("re_wr49", wq[49], {32'(e1), 8'd49, mem[16'hC031]});
        bad = 0;
        for (int i = 0; i < 160; i++) if (oam[i] !== mem[{8'hC1, 8'(i)}]) bad++;
        check("re_oam_bad", bad, 0);
        check("re_busy_len", busy_cnt, (e1 - e0) + 162);
        check("re_rdata", m_rdata, 8'hC1);
    endtask

    task automatic reset_test(input logic [7:0] v);
        logic found;
        found = 1'b0;
        kick(v);
        for (int k = 0; k < 150; k++) begin
            if (m_req && m_addr == {src_of(v), 8'd80}) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rs_found80", found, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("rs_busy", m_busy, 1'b0);
        check("rs_req", m_req, 1'b0);
        check("rs_owe", m_owe, 1'b0);
        check("rs_rdata", m_rdata, 8'h00);
        rst = 1'b0;
        rq.delete();
        wq.delete();
        repeat (20) @(negedge clk);
        check("rs_no_rd", rq.size(), 0);
        check("rs_no_wr", wq.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        rst = 1'b1;
        we = 1'b0;
        wdata = 8'h00;
        sel = 1'b0;
        repeat (3) @(negedge clk);
        check("r_busy", busy1, 1'b0);
        check("r_req", req1, 1'b0);
        check("r_owe", owe1, 1'b0);
        check("r_addr", addr1, 16'h0000);
        check("r_oaddr", oaddr1, 8'h00);
        check("r_odata", odata1, 8'h00);
        check("r_rdata", rdata1, 8'h00);
        check("r_busy2", busy2, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        xfer(8'h01);
        xfer(8'hFE);
        for (int n = 0; n < 3; n++) xfer(8'($urandom));
        restart_test();
        reset_test(8'($urandom_range(0, 255)));

        sel = 1'b1;
        repeat (2) @(negedge clk);
        xfer(8'($urandom));
        xfer(8'hE5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
